// File: rtl/jam_pkg.sv
// Shared constants and state encoding for the job-assignment datapath.
// Widths here must agree with the assignment engine that consumes the cost table.
package jam_pkg;

    localparam int N_WORK  = 8;
    localparam int COST_W  = 7;
    localparam int TOTAL_W = 10;
    localparam int COL_W   = $clog2(N_WORK);
    localparam int IDX_W   = 2 * COL_W;
    localparam int N_ENTRY = N_WORK * N_WORK;

    localparam logic [COST_W-1:0] COST_MAX = '1;

    typedef enum logic {
        LOAD  = 1'b0,
        READY = 1'b1
    } state_t;

    function automatic logic [COST_W-1:0] min_cost(input logic [COST_W-1:0] a,
                                                   input logic [COST_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/cost_ram.sv
// 64x7 cost storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; readers gate the output until a full load.
module cost_ram
    import jam_pkg::*;
(
    input  logic              CLK,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [COST_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [COST_W-1:0] rdata
);

    logic [COST_W-1:0] mem [N_ENTRY];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cost_table_loader.sv
// Streams a row-major 8x8 cost table into local storage and tracks the sum of
// row minima as a lower bound for the downstream assignment engine.
module cost_table_loader
    import jam_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               In_valid,
    output logic               In_ready,
    input  logic [COST_W-1:0]  In_data,
    input  logic               Reload,
    input  logic [COL_W-1:0]   W,
    input  logic [COL_W-1:0]   J,
    output logic [COST_W-1:0]  Cost,
    output logic               Table_ready,
    output logic [TOTAL_W-1:0] LowerBound
);

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   idx;
    logic [COST_W-1:0]  row_min;
    logic [COST_W-1:0]  row_min_new;
    logic [TOTAL_W-1:0] lower_bound;
    logic               table_ready_q;
    logic               handshake;
    logic               row_last;
    logic [COST_W-1:0]  ram_rdata;

    assign handshake   = In_valid && In_ready;
    assign row_last    = (idx[COL_W-1:0] == COL_W'(N_WORK - 1));
    assign row_min_new = min_cost(row_min, In_data);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (handshake && idx == IDX_W'(N_ENTRY - 1)) state_next = READY;
            READY:   if (Reload) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    always_comb begin
        In_ready = (state == LOAD) && !Reload;
        Cost     = table_ready_q ? ram_rdata : '0;
    end

    // Reload in either state discards progress; the accumulator only moves on row ends.
    always_ff @(posedge CLK) begin
        if (RST) begin
            idx           <= '0;
            row_min       <= COST_MAX;
            lower_bound   <= '0;
            table_ready_q <= 1'b0;
        end else begin
            table_ready_q <= (state_next == READY);
            if (Reload) begin
                idx         <= '0;
                row_min     <= COST_MAX;
                lower_bound <= '0;
            end else if (handshake) begin
                idx <= idx + IDX_W'(1);
                if (row_last) begin
                    lower_bound <= lower_bound + {{(TOTAL_W - COST_W){1'b0}}, row_min_new};
                    row_min     <= COST_MAX;
                end else begin
                    row_min <= row_min_new;
                end
            end
        end
    end

    cost_ram u_cost_ram (
        .CLK   (CLK),
        .we    (handshake),
        .waddr (idx),
        .wdata (In_data),
        .raddr ({W, J}),
        .rdata (ram_rdata)
    );

    assign Table_ready = table_ready_q;
    assign LowerBound  = lower_bound;

endmodule
